// File: rtl/mux_scan_sel.sv
// mux_scan_sel: N-channel, W-bit registered multiplexer.
// Direct mode selects a channel by index. Scan mode round-robins over an
// enable mask and holds each channel for DWELL cycles.
module mux_scan_sel #(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] din,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              start,
  output logic [W-1:0]      y,
  output logic [SELW-1:0]   y_ch,
  output logic              y_vld,
  output logic              busy,
  output logic              wrap
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state;
  logic [SELW-1:0] cur;
  logic [CNTW-1:0] cnt;

  logic [W-1:0]    ch_data [N_CH];
  logic [SELW-1:0] low_idx;
  logic            low_found;
  logic [SELW-1:0] above_idx;
  logic            above_found;
  logic [SELW-1:0] nxt_idx;
  logic            direct_ok;
  logic [W-1:0]    direct_data;

  // Unpack the flat channel bus into an indexable array
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_data[i] = din[i*W +: W];
    end
  end

  // Find the lowest enabled channel and the first enabled channel above cur
  always_comb begin
    low_idx     = '0;
    low_found   = 1'b0;
    above_idx   = '0;
    above_found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_en[i] && !low_found) begin
        low_idx   = SELW'(i);
        low_found = 1'b1;
      end
      if (ch_en[i] && !above_found && (SELW'(i) > cur)) begin
        above_idx   = SELW'(i);
        above_found = 1'b1;
      end
    end
    // Falling back to the lowest index means the pass has wrapped
    nxt_idx = above_found ? above_idx : low_idx;
  end

  // Direct-mode data; indices past the last channel give an invalid zero
  always_comb begin
    direct_ok   = ({1'b0, sel} < (SELW+1)'(N_CH));
    direct_data = '0;
    if (direct_ok) begin
      direct_data = ch_data[sel];
    end
  end

  // Scan FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      cnt   <= '0;
      y     <= '0;
      y_ch  <= '0;
      y_vld <= 1'b0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
    end else if (!mode) begin
      // Direct capture also cancels any running scan
      state <= IDLE;
      cnt   <= '0;
      y     <= direct_data;
      y_ch  <= sel;
      y_vld <= direct_ok;
      busy  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          y_vld <= 1'b0;
          wrap  <= 1'b0;
          busy  <= 1'b0;
          if (start && low_found) begin
            state <= SCAN;
            cur   <= low_idx;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          y     <= ch_data[cur];
          y_ch  <= cur;
          y_vld <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!low_found) begin
              state <= IDLE;
              busy  <= 1'b0;
              wrap  <= 1'b0;
            end else begin
              cur  <= nxt_idx;
              wrap <= !above_found;
            end
          end else begin
            cnt  <= cnt + 1'b1;
            wrap <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          y_vld <= 1'b0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed self-checking bench for mux_scan_sel.
module tb_mux_scan_sel;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  ch_en;
  logic        start;
  logic [7:0]  y;
  logic [1:0]  y_ch;
  logic        y_vld;
  logic        busy;
  logic        wrap;

  logic [11:0] din3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [2:0]  ch_en3;
  logic        start3;
  logic [3:0]  y3;
  logic [1:0]  y_ch3;
  logic        y_vld3;
  logic        busy3;
  logic        wrap3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_scan_sel #(.N_CH(4), .W(8), .DWELL(4)) u_dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode),
    .ch_en(ch_en), .start(start), .y(y), .y_ch(y_ch), .y_vld(y_vld),
    .busy(busy), .wrap(wrap)
  );

  mux_scan_sel #(.N_CH(3), .W(4), .DWELL(1)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel(sel3), .mode(mode3),
    .ch_en(ch_en3), .start(start3), .y(y3), .y_ch(y_ch3), .y_vld(y_vld3),
    .busy(busy3), .wrap(wrap3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int idx);
    logic [31:0] d;
    d = 32'hD3C2B1A0;
    return d[idx*8 +: 8];
  endfunction

  initial begin
    rst = 1'b1; din = 32'hD3C2B1A0; sel = 2'd0; mode = 1'b0; ch_en = 4'b0; start = 1'b0;
    din3 = {4'h9, 4'h6, 4'h3}; sel3 = 2'd0; mode3 = 1'b0; ch_en3 = 3'b0; start3 = 1'b0;

    // Reset state
    tick();
    check("rst_y", y, 0);
    check("rst_ych", y_ch, 0);
    check("rst_vld", y_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_wrap", wrap, 0);
    rst = 1'b0;

    // Direct mode
    sel = 2'd2;
    tick();
    check("dir_y2", y, 8'hC2);
    check("dir_ch2", y_ch, 2);
    check("dir_vld2", y_vld, 1);
    sel = 2'd0;
    tick();
    check("dir_y0", y, 8'hA0);
    check("dir_ch0", y_ch, 0);

    // Scan all four channels, DWELL=4
    mode = 1'b1; ch_en = 4'b1111;
    tick();
    check("idle1_vld", y_vld, 0);
    check("idle1_yhold", y, 8'hA0);
    start = 1'b1;
    tick();
    check("start_vld", y_vld, 0);
    check("start_busy", busy, 1);
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      check("s4_ch", y_ch, (k / 4) % 4);
      check("s4_y", y, byte_of((k / 4) % 4));
      check("s4_vld", y_vld, 1);
      check("s4_busy", busy, 1);
      check("s4_wrap", wrap, (k % 16 == 15) ? 1 : 0);
    end

    // Sparse mask, then mask change mid-dwell on channel 3
    mode = 1'b0;
    tick();
    check("stop_busy", busy, 0);
    mode = 1'b1; ch_en = 4'b1010; start = 1'b1;
    tick();
    check("sp_start_vld", y_vld, 0);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("sp_ch", y_ch, (k < 4) ? 1 : (k < 8) ? 3 : 2);
      check("sp_wrap", wrap, (k == 7 || k == 11 || k == 15) ? 1 : 0);
      if (k == 4) ch_en = 4'b0100;
    end

    // Start with empty mask is ignored
    mode = 1'b0; sel = 2'd0;
    tick();
    check("e_pre_y", y, 8'hA0);
    mode = 1'b1; ch_en = 4'b0000; start = 1'b1;
    tick();
    check("e_busy", busy, 0);
    check("e_vld", y_vld, 0);
    check("e_y", y, 8'hA0);
    tick();
    check("e_busy2", busy, 0);
    check("e_y2", y, 8'hA0);
    start = 1'b0;

    // Reset mid-scan at the 6th sample
    ch_en = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("r_pre_ch", y_ch, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_y", y, 0);
    check("r_ych", y_ch, 0);
    check("r_vld", y_vld, 0);
    check("r_busy", busy, 0);
    check("r_wrap", wrap, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("r_idle_vld", y_vld, 0);
      check("r_idle_busy", busy, 0);
    end

    // Leave scan via mode drop
    ch_en = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("m_ch1", y_ch, 1);
    check("m_y1", y, 8'hB1);
    mode = 1'b0; sel = 2'd3;
    tick();
    check("m_y", y, 8'hD3);
    check("m_ych", y_ch, 3);
    check("m_vld", y_vld, 1);
    check("m_busy", busy, 0);
    check("m_wrap", wrap, 0);
    mode = 1'b1;
    tick();
    check("m_re_busy", busy, 0);
    check("m_re_vld", y_vld, 0);
    tick();
    check("m_re_busy2", busy, 0);

    // 3-channel instance: out-of-range select and DWELL=1 scan
    sel3 = 2'd3;
    tick();
    check("n3_oor_y", y3, 0);
    check("n3_oor_vld", y_vld3, 0);
    check("n3_oor_ch", y_ch3, 3);
    sel3 = 2'd2;
    tick();
    check("n3_y2", y3, 4'h9);
    check("n3_vld2", y_vld3, 1);
    mode3 = 1'b1; ch_en3 = 3'b101; start3 = 1'b1;
    tick();
    check("n3_start_vld", y_vld3, 0);
    start3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("n3_ch", y_ch3, (k % 2 == 0) ? 0 : 2);
      check("n3_y", y3, (k % 2 == 0) ? 4'h3 : 4'h9);
      check("n3_wrap", wrap3, (k % 2 == 1) ? 1 : 0);
    end
    ch_en3 = 3'b000;
    tick();
    check("n3_last_vld", y_vld3, 1);
    tick();
    check("n3_off_vld", y_vld3, 0);
    check("n3_off_busy", busy3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
